imem_port_arbiter: RTL and testbench

//  Shares the single byte-addressed instruction-memory port (RW/Addr/DataIn/DataOut) between two requesters.
//  The CPU fetch unit issues read requests; the program loader issues 32-bit write requests.

---
 rtl/imem_port_arbiter_if.sv | 28 ++
 rtl/imem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_imem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_port_arbiter_if.sv
// Requester, status and memory-side signals of the instruction-memory port arbiter.
// slave: the arbiter's view; master: requesters plus memory.
interface imem_port_arbiter_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_data;
  logic        load_req;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_ack;
  logic        err;
  logic        busy;
  logic        mem_RW;
  logic [31:0] mem_Addr;
  logic [31:0] mem_DataIn;
  logic [31:0] mem_DataOut;

  modport slave (
    input  fetch_req, fetch_addr, load_req, load_addr, load_data, mem_DataOut,
    output fetch_ack, fetch_data, load_ack, err, busy, mem_RW, mem_Addr, mem_DataIn
  );

  modport master (
    output fetch_req, fetch_addr, load_req, load_addr, load_data, mem_DataOut,
    input  fetch_ack, fetch_data, load_ack, err, busy, mem_RW, mem_Addr, mem_DataIn
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares one instruction-memory port between CPU fetch (reads) and the program loader (writes).
// Optional IMEM_ALIGN_CHECK_EN: unaligned word addresses are rejected with err.
module imem_port_arbiter #(
  parameter int unsigned MEM_BYTES      = 1024,
  parameter int unsigned MAX_LOAD_BURST = 4
) (
  input logic              CLK,
  input logic              Reset,
  imem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StGrant, StAck} state_e;

  state_e      r_state, w_state_next;
  logic [3:0]  r_streak, w_streak_next;
  logic        r_is_load, w_is_load_next;
  logic        r_illegal, w_illegal_next;
  logic        r_mem_rw, w_mem_rw_next;
  logic [31:0] r_mem_addr, w_mem_addr_next;
  logic [31:0] r_mem_datain, w_mem_datain_next;
  logic        r_fetch_ack, w_fetch_ack_next;
  logic        r_load_ack, w_load_ack_next;
  logic        r_err, w_err_next;
  logic [31:0] r_fetch_data, w_fetch_data_next;

  logic        w_any_req;
  logic        w_load_wins;
  logic [31:0] w_sel_addr;
  logic [32:0] w_addr_last;
  logic        w_range_bad;
  logic        w_align_bad;
  logic        w_sel_illegal;

  assign w_any_req   = bus.fetch_req | bus.load_req;
  // Fetch only overtakes a pending load once the streak limit is reached.
  assign w_load_wins = bus.load_req &
                       ~(bus.fetch_req & (r_streak == 4'(MAX_LOAD_BURST)));
  assign w_sel_addr  = w_load_wins ? bus.load_addr : bus.fetch_addr;
  assign w_addr_last = {1'b0, w_sel_addr} + 33'd3;
  assign w_range_bad = w_addr_last > 33'(MEM_BYTES - 1);

`ifdef IMEM_ALIGN_CHECK_EN
  assign w_align_bad = |w_sel_addr[1:0];
`else
  assign w_align_bad = 1'b0;
`endif

  assign w_sel_illegal = w_range_bad | w_align_bad;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state      <= StIdle;
      r_streak     <= 4'd0;
      r_is_load    <= 1'b0;
      r_illegal    <= 1'b0;
      r_mem_rw     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_datain <= 32'd0;
      r_fetch_ack  <= 1'b0;
      r_load_ack   <= 1'b0;
      r_err        <= 1'b0;
      r_fetch_data <= 32'd0;
    end else begin
      r_state      <= w_state_next;
      r_streak     <= w_streak_next;
      r_is_load    <= w_is_load_next;
      r_illegal    <= w_illegal_next;
      r_mem_rw     <= w_mem_rw_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_datain <= w_mem_datain_next;
      r_fetch_ack  <= w_fetch_ack_next;
      r_load_ack   <= w_load_ack_next;
      r_err        <= w_err_next;
      r_fetch_data <= w_fetch_data_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_is_load_next    = r_is_load;
    w_illegal_next    = r_illegal;
    w_mem_rw_next     = r_mem_rw;
    w_mem_addr_next   = r_mem_addr;
    w_mem_datain_next = r_mem_datain;
    w_fetch_ack_next  = 1'b0;
    w_load_ack_next   = 1'b0;
    w_err_next        = r_err;
    w_fetch_data_next = r_fetch_data;

    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_state_next      = StGrant;
          w_is_load_next    = w_load_wins;
          w_illegal_next    = w_sel_illegal;
          w_mem_addr_next   = w_sel_addr;
          w_mem_datain_next = bus.load_data;
          w_mem_rw_next     = w_load_wins & ~w_sel_illegal;
        end
      end
      StGrant: begin
        w_state_next  = StAck;
        w_mem_rw_next = 1'b0;
        w_err_next    = r_illegal;
        if (r_is_load) begin
          w_load_ack_next = 1'b1;
        end else begin
          w_fetch_ack_next  = 1'b1;
          w_fetch_data_next = r_illegal ? 32'd0 : bus.mem_DataOut;
        end
      end
      StAck: begin
        w_state_next = StIdle;
        w_err_next   = 1'b0;
      end
      default: begin
        w_state_next  = StIdle;
        w_mem_rw_next = 1'b0;
      end
    endcase
  end

  // Streak counts load grants that passed over a waiting fetch.
  always_comb begin
    w_streak_next = r_streak;
    if (!bus.fetch_req) begin
      w_streak_next = 4'd0;
    end else if (r_state == StIdle && w_any_req) begin
      w_streak_next = w_load_wins ? r_streak + 4'd1 : 4'd0;
    end
  end

  assign bus.fetch_ack  = r_fetch_ack;
  assign bus.fetch_data = r_fetch_data;
  assign bus.load_ack   = r_load_ack;
  assign bus.err        = r_err;
  assign bus.busy       = (r_state != StIdle);
  assign bus.mem_RW     = r_mem_rw;
  assign bus.mem_Addr   = r_mem_addr;
  assign bus.mem_DataIn = r_mem_datain;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a 1 KiB byte memory model.
module tb_imem_port_arbiter;

  logic CLK;
  logic Reset;
  logic mem_init;
  int   n_cmp;
  int   n_bad;

  logic [7:0] mem [1024];

  imem_port_arbiter_if bus ();

  imem_port_arbiter #(
    .MEM_BYTES      (1024),
    .MAX_LOAD_BURST (4)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory: combinational read, write committed on the clock edge while mem_RW is high.
  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) ^ 8'hA5;
    end else if (bus.mem_RW && bus.mem_Addr <= 32'd1020) begin
      mem[bus.mem_Addr[9:0]]         <= bus.mem_DataIn[7:0];
      mem[bus.mem_Addr[9:0] + 10'd1] <= bus.mem_DataIn[15:8];
      mem[bus.mem_Addr[9:0] + 10'd2] <= bus.mem_DataIn[23:16];
      mem[bus.mem_Addr[9:0] + 10'd3] <= bus.mem_DataIn[31:24];
    end
  end

  always_comb begin
    bus.mem_DataOut = 32'd0;
    if (bus.mem_Addr <= 32'd1020) begin
      bus.mem_DataOut = {mem[bus.mem_Addr[9:0] + 10'd3], mem[bus.mem_Addr[9:0] + 10'd2],
                         mem[bus.mem_Addr[9:0] + 10'd1], mem[bus.mem_Addr[9:0]]};
    end
  end

  function automatic logic [31:0] rd_word(input int a);
    return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d, output logic e,
                         output int lat, output logic saw_rw);
    logic got;
    bus.load_addr = a;
    bus.load_data = d;
    bus.load_req  = 1'b1;
    lat = 0;
    got = 1'b0;
    saw_rw = 1'b0;
    e = 1'b0;
    while (lat < 10 && !got) begin
      step();
      lat++;
      if (bus.mem_RW) saw_rw = 1'b1;
      if (bus.load_ack) got = 1'b1;
    end
    if (!got) lat = 99;
    e = bus.err;
    bus.load_req = 1'b0;
    step();
    chk("load_ack_pulse", {31'd0, bus.load_ack}, 32'd0);
  endtask

  task automatic do_fetch(input logic [31:0] a, output logic [31:0] d, output logic e,
                          output int lat);
    logic got;
    bus.fetch_addr = a;
    bus.fetch_req  = 1'b1;
    lat = 0;
    got = 1'b0;
    while (lat < 10 && !got) begin
      step();
      lat++;
      if (bus.fetch_ack) got = 1'b1;
    end
    if (!got) lat = 99;
    d = bus.fetch_data;
    e = bus.err;
    bus.fetch_req = 1'b0;
    step();
    chk("fetch_ack_pulse", {31'd0, bus.fetch_ack}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic        e;
    logic        saw;
    logic [31:0] d;
    logic [31:0] fd;
    logic [31:0] seq;
    int          lat;
    int          cyc;
    int          lcyc;
    int          fcyc;
    int          nack;
    int          k;

    n_cmp = 0;
    n_bad = 0;
    Reset = 1'b1;
    mem_init = 1'b1;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = 32'd0;
    bus.load_req   = 1'b0;
    bus.load_addr  = 32'd0;
    bus.load_data  = 32'd0;
    repeat (3) step();

    chk("rst_mem_rw",     {31'd0, bus.mem_RW}, 32'd0);
    chk("rst_busy",       {31'd0, bus.busy}, 32'd0);
    chk("rst_mem_addr",   bus.mem_Addr, 32'd0);
    chk("rst_fetch_data", bus.fetch_data, 32'd0);
    chk("rst_acks",       {30'd0, bus.fetch_ack, bus.load_ack}, 32'd0);
    mem_init = 1'b0;
    Reset = 1'b0;
    step();

    // T1: reset while a write is in GRANT
    bus.load_addr = 32'h20;
    bus.load_data = 32'h12345678;
    bus.load_req  = 1'b1;
    step();
    chk("t1_grant_rw",   {31'd0, bus.mem_RW}, 32'd1);
    chk("t1_grant_busy", {31'd0, bus.busy}, 32'd1);
    #1 Reset = 1'b1;
    #1;
    chk("t1_rst_rw",     {31'd0, bus.mem_RW}, 32'd0);
    chk("t1_rst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("t1_rst_addr",   bus.mem_Addr, 32'd0);
    chk("t1_rst_datain", bus.mem_DataIn, 32'd0);
    bus.load_req = 1'b0;
    step();
    step();
    Reset = 1'b0;
    step();
    chk("t1_mem_kept",   rd_word(32'h20), 32'h86878485);

    // T2: load then fetch the same word
    do_load(32'h10, 32'hDEADBEEF, e, lat, saw);
    chk("t2_load_err", {31'd0, e}, 32'd0);
    chk("t2_load_lat", lat, 32'd2);
    chk("t2_load_rw",  {31'd0, saw}, 32'd1);
    do_fetch(32'h10, d, e, lat);
    chk("t2_fetch_data", d, 32'hDEADBEEF);
    chk("t2_fetch_err",  {31'd0, e}, 32'd0);
    chk("t2_fetch_lat",  lat, 32'd2);

    // T3: simultaneous requests
    bus.fetch_addr = 32'h10;
    bus.load_addr  = 32'h40;
    bus.load_data  = 32'h01020304;
    bus.fetch_req  = 1'b1;
    bus.load_req   = 1'b1;
    cyc = 0; lcyc = 0; fcyc = 0; fd = 32'd0;
    while (cyc < 20 && fcyc == 0) begin
      step();
      cyc++;
      if (bus.load_ack) begin lcyc = cyc; bus.load_req = 1'b0; end
      if (bus.fetch_ack) begin fcyc = cyc; fd = bus.fetch_data; bus.fetch_req = 1'b0; end
    end
    bus.load_req  = 1'b0;
    bus.fetch_req = 1'b0;
    step();
    chk("t3_load_cyc",  lcyc, 32'd2);
    chk("t3_fetch_cyc", fcyc, 32'd5);
    chk("t3_fetch_data", fd, 32'hDEADBEEF);
    chk("t3_mem_40",    rd_word(32'h40), 32'h01020304);

    // T4: starvation limit, 1 = fetch ack
    k = 0; seq = 32'd0; nack = 0; cyc = 0; fd = 32'd0;
    bus.fetch_addr = 32'h10;
    bus.load_addr  = 32'h100;
    bus.load_data  = 32'hA0000000;
    bus.fetch_req  = 1'b1;
    bus.load_req   = 1'b1;
    while (cyc < 100 && nack < 10) begin
      step();
      cyc++;
      if (bus.load_ack) begin
        seq = {seq[30:0], 1'b0};
        nack++;
        k++;
        bus.load_addr = 32'h100 + 32'(4 * k);
        bus.load_data = 32'hA0000000 + 32'(k);
      end
      if (bus.fetch_ack) begin
        seq = {seq[30:0], 1'b1};
        nack++;
        fd = bus.fetch_data;
      end
    end
    bus.fetch_req = 1'b0;
    bus.load_req  = 1'b0;
    step();
    step();
    chk("t4_ack_count", nack, 32'd10);
    chk("t4_sequence",  seq, 32'h21);
    chk("t4_fetch_data", fd, 32'hDEADBEEF);
    chk("t4_mem_100",   rd_word(32'h100), 32'hA0000000);
    chk("t4_mem_11c",   rd_word(32'h11C), 32'hA0000007);

    // T5: range boundary
    do_load(32'h3FD, 32'h11223344, e, lat, saw);
    chk("t5_bad_err",  {31'd0, e}, 32'd1);
    chk("t5_bad_rw",   {31'd0, saw}, 32'd0);
    chk("t5_bad_lat",  lat, 32'd2);
    chk("t5_mem_kept", rd_word(32'h3FC), 32'h5A5B5859);
    do_fetch(32'h3FD, d, e, lat);
    chk("t5_fbad_err",  {31'd0, e}, 32'd1);
    chk("t5_fbad_data", d, 32'd0);
    do_fetch(32'hFFFFFFFE, d, e, lat);
    chk("t5_wrap_err",  {31'd0, e}, 32'd1);
    do_load(32'h3FC, 32'hCAFEF00D, e, lat, saw);
    chk("t5_ok_err", {31'd0, e}, 32'd0);
    chk("t5_ok_rw",  {31'd0, saw}, 32'd1);
    do_fetch(32'h3FC, d, e, lat);
    chk("t5_ok_data", d, 32'hCAFEF00D);
    chk("t5_ok_ferr", {31'd0, e}, 32'd0);

    // T6: unaligned fetch
    do_fetch(32'h2, d, e, lat);
`ifdef IMEM_ALIGN_CHECK_EN
    chk("t6_align_err",  {31'd0, e}, 32'd1);
    chk("t6_align_data", d, 32'd0);
`else
    chk("t6_align_err",  {31'd0, e}, 32'd0);
    chk("t6_align_data", d, 32'hA0A1A6A7);
`endif
    chk("t6_lat", lat, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
